addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit add/sub datapath (`adder_16bit_s`) between two requesters. It accepts one operation at a time over a valid/ready handshake and drives registered operands into the adder. It waits a fixed settle time, then captures SUM/C_out/O and returns them with the requester ID over a valid/ready response channel. It sits between the requesting blocks and the combinational `adder_16bit_s` instance.

---
 rtl/addsub_arbiter.sv | 149 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin front end that shares one combinational 16-bit
// add/sub datapath between two requesters. One operation is in flight at a
// time: operands are registered onto the adder, held for SETTLE cycles, then
// the adder outputs are captured and returned with the requester ID.
module addsub_arbiter #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic             req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic             req1_op,

    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Add_ctrl,
    input  logic [WIDTH-1:0] SUM,
    input  logic             C_out,
    input  logic             O,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf
);

    // SETTLE is at most 15, so the remaining-cycles counter fits in 4 bits.
    localparam int              CNT_W       = 4;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               last;        // ID of the most recent grant
    logic [CNT_W-1:0]   settle_cnt;  // cycles left before sampling the adder

    logic               grant_valid;
    logic               grant_id;
    logic [WIDTH-1:0]   grant_a;
    logic [WIDTH-1:0]   grant_b;
    logic               grant_op;

    // Round-robin decision: only in IDLE and never while reset is asserted.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the ifs leaves it unassigned (that would infer a latch).
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (rst_n && (state == IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Ready is raised only toward the winner, so a grant is also a handshake.
    assign req0_ready = grant_valid & ~grant_id;
    assign req1_ready = grant_valid &  grant_id;

    // Select the winning requester's operation for loading onto the adder.
    always_comb begin
        grant_a  = req0_A;
        grant_b  = req0_B;
        grant_op = req0_op;
        if (grant_id) begin
            grant_a  = req1_A;
            grant_b  = req1_B;
            grant_op = req1_op;
        end
    end

    // Sequencer: accept, hold operands while the adder settles, capture, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            settle_cnt <= '0;
            A          <= '0;
            B          <= '0;
            Add_ctrl   <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        A          <= grant_a;
                        B          <= grant_b;
                        Add_ctrl   <= grant_op;
                        rsp_id     <= grant_id;
                        last       <= grant_id;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (settle_cnt == '0) begin
                        rsp_sum   <= SUM;
                        rsp_cout  <= C_out;
                        rsp_ovf   <= O;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Data registers keep their value after the handshake.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: behavioural reference model with per-cycle
// comparison, an adder model feeding SUM/C_out/O, directed scenarios with
// literal expectations, and a second instance built with SETTLE=3.
module tb_addsub_arbiter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance (SETTLE=1)
    logic         req0_valid = 0, req1_valid = 0, req0_op = 1, req1_op = 1;
    logic [W-1:0] req0_A = 0, req0_B = 0, req1_A = 0, req1_B = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] A, B, SUM, rsp_sum;
    logic         Add_ctrl, C_out, O;
    logic         rsp_valid, rsp_ready = 1, rsp_id, rsp_cout, rsp_ovf;

    addsub_arbiter #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
        .req0_B(req0_B), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
        .req1_B(req1_B), .req1_op(req1_op),
        .A(A), .B(B), .Add_ctrl(Add_ctrl), .SUM(SUM), .C_out(C_out), .O(O),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    // Second instance (SETTLE=3); requester 1 idle, consumer always ready
    logic         v3 = 0, op3 = 1;
    logic [W-1:0] a3_in = 0, b3_in = 0;
    logic         rdy3, rdy3_1, ctrl3, cout3, o3, rv3, rid3, rcout3, rovf3;
    logic [W-1:0] A3, B3, SUM3, rsum3;

    addsub_arbiter #(.WIDTH(W), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v3), .req0_ready(rdy3), .req0_A(a3_in), .req0_B(b3_in),
        .req0_op(op3),
        .req1_valid(1'b0), .req1_ready(rdy3_1), .req1_A(16'h0),
        .req1_B(16'h0), .req1_op(1'b1),
        .A(A3), .B(B3), .Add_ctrl(ctrl3), .SUM(SUM3), .C_out(cout3), .O(o3),
        .rsp_valid(rv3), .rsp_ready(1'b1), .rsp_id(rid3),
        .rsp_sum(rsum3), .rsp_cout(rcout3), .rsp_ovf(rovf3)
    );

    // Combinational adder models: add, or add two's complement of B.
    assign {C_out, SUM} = Add_ctrl ? ({1'b0, A} + {1'b0, B})
                                   : ({1'b0, A} + {1'b0, ~B} + 17'd1);
    assign O = (Add_ctrl ? (A[15] == B[15]) : (A[15] != B[15])) && (SUM[15] != A[15]);
    assign {cout3, SUM3} = ctrl3 ? ({1'b0, A3} + {1'b0, B3})
                                 : ({1'b0, A3} + {1'b0, ~B3} + 17'd1);
    assign o3 = (ctrl3 ? (A3[15] == B3[15]) : (A3[15] != B3[15])) && (SUM3[15] != A3[15]);

    int checks = 0;
    int failures = 0;
    bit run = 0;
    int rsp_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (main instance) ----------------
    // Result by integer arithmetic: signed range test for overflow,
    // borrow-free test (a >= b) for the subtract carry.
    task automatic model_result(input logic [W-1:0] a, b, input logic op,
                                output logic [W-1:0] s, output logic c, output logic v);
        int sa, sb, r, u;
        sa = $signed(a);
        sb = $signed(b);
        r  = op ? sa + sb : sa - sb;
        u  = op ? int'(a) + int'(b) : int'(a) - int'(b) + 65536;
        s  = u[15:0];
        c  = op ? (u > 65535) : (a >= b);
        v  = (r > 32767) || (r < -32768);
    endtask

    logic         m_busy = 0, m_rsp_valid = 0, m_last = 1, m_id = 0;
    int           m_wait = 0;
    logic [W-1:0] m_a = 0, m_b = 0, m_sum = 0;
    logic         m_op = 1, m_cout = 0, m_ovf = 0;

    function automatic logic exp_rdy(input int id);
        logic idle;
        idle = rst_n && !m_busy && !m_rsp_valid;
        if (id == 0) return idle && req0_valid && (!req1_valid || m_last);
        return idle && req1_valid && (!req0_valid || !m_last);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_rsp_valid = 0; m_last = 1; m_id = 0; m_wait = 0;
            m_a = 0; m_b = 0; m_op = 1; m_sum = 0; m_cout = 0; m_ovf = 0;
        end else if (m_rsp_valid) begin
            if (rsp_ready) m_rsp_valid = 0;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                model_result(m_a, m_b, m_op, m_sum, m_cout, m_ovf);
                m_busy = 0;
                m_rsp_valid = 1;
            end
        end else if (exp_rdy(0) || exp_rdy(1)) begin
            m_id   = exp_rdy(1);
            m_last = m_id;
            m_a    = m_id ? req1_A : req0_A;
            m_b    = m_id ? req1_B : req0_B;
            m_op   = m_id ? req1_op : req0_op;
            m_busy = 1;
            m_wait = 1;  // SETTLE of the main instance
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            check("req0_ready", req0_ready, exp_rdy(0));
            check("req1_ready", req1_ready, exp_rdy(1));
            check("A", A, m_a);
            check("B", B, m_b);
            check("Add_ctrl", Add_ctrl, m_op);
            check("rsp_valid", rsp_valid, m_rsp_valid);
            check("rsp_id", rsp_id, m_id);
            check("rsp_sum", rsp_sum, m_sum);
            check("rsp_cout", rsp_cout, m_cout);
            check("rsp_ovf", rsp_ovf, m_ovf);
            if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present an operation and hold it until the handshake edge; valid is
    // left asserted so back-to-back calls keep the requester continuously valid.
    task automatic send(input int id, input logic [W-1:0] a, b, input logic op);
        int n = 0;
        if (id == 0) begin
            req0_valid = 1; req0_A = a; req0_B = b; req0_op = op;
        end else begin
            req1_valid = 1; req1_A = a; req1_B = b; req1_op = op;
        end
        @(negedge clk);
        while (!(id == 0 ? req0_ready : req1_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("grant_timeout_req%0d", id), (id == 0 ? req0_ready : req1_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic wait_rsp(input string nm);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(nm, rsp_valid, 1);
    endtask

    localparam logic [W-1:0] R0_A [3] = '{16'h0010, 16'h8000, 16'h0003};
    localparam logic [W-1:0] R0_B [3] = '{16'h0020, 16'h8000, 16'h0009};
    localparam logic [W-1:0] R1_A [3] = '{16'h1000, 16'h7FFE, 16'hABCD};
    localparam logic [W-1:0] R1_B [3] = '{16'h0001, 16'hFFFF, 16'h1111};
    localparam logic         R_OP [3] = '{1'b1, 1'b1, 1'b0};
    localparam int           EXP_ORDER [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        logic [W-1:0] snap;
        int n;

        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        run = 1;

        // Reset values
        @(negedge clk);
        check("reset_A", A, 16'h0000);
        check("reset_B", B, 16'h0000);
        check("reset_Add_ctrl", Add_ctrl, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_sum", rsp_sum, 16'h0000);
        @(posedge clk); #1;

        // Basic add, requester 0
        send(0, 16'h1234, 16'h0001, 1'b1);
        drop_all();
        wait_rsp("rsp_wait_basic");
        check("basic_id", rsp_id, 0);
        check("basic_sum", rsp_sum, 16'h1235);
        check("basic_cout", rsp_cout, 0);
        check("basic_ovf", rsp_ovf, 0);
        @(posedge clk); #1;

        // Overflow / carry / subtract, requester 1
        send(1, 16'h7FFF, 16'h0001, 1'b1);
        drop_all();
        wait_rsp("rsp_wait_ovf");
        check("ovf_id", rsp_id, 1);
        check("ovf_sum", rsp_sum, 16'h8000);
        check("ovf_ovf", rsp_ovf, 1);
        @(posedge clk); #1;
        send(1, 16'hFFFF, 16'h0001, 1'b1);
        drop_all();
        wait_rsp("rsp_wait_carry");
        check("carry_sum", rsp_sum, 16'h0000);
        check("carry_cout", rsp_cout, 1);
        check("carry_ovf", rsp_ovf, 0);
        @(posedge clk); #1;
        send(1, 16'h0005, 16'h0003, 1'b0);
        drop_all();
        wait_rsp("rsp_wait_sub");
        check("sub_sum", rsp_sum, 16'h0002);
        check("sub_ovf", rsp_ovf, 0);
        @(posedge clk); #1;

        // Contention: both continuously valid; last grant was requester 1
        rsp_log.delete();
        fork
            for (int i = 0; i < 3; i++) send(0, R0_A[i], R0_B[i], R_OP[i]);
            for (int i = 0; i < 3; i++) send(1, R1_A[i], R1_B[i], R_OP[i]);
        join
        drop_all();
        n = 0;
        while (rsp_log.size() < 6 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rr_count", rsp_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rsp_log.size()) check($sformatf("rr_order_%0d", i), rsp_log[i], EXP_ORDER[i]);
        @(posedge clk); #1;

        // Response stall
        rsp_ready = 0;
        send(0, 16'h0100, 16'h0020, 1'b1);
        req0_valid = 0;
        req1_valid = 1; req1_A = 16'h0002; req1_B = 16'h0003; req1_op = 1'b1;
        wait_rsp("rsp_wait_stall");
        snap = rsp_sum;
        check("stall_sum", snap, 16'h0120);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_sum_stable", rsp_sum, snap);
            check("stall_rdy0", req0_ready, 0);
            check("stall_rdy1", req1_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        check("stall_release_valid", rsp_valid, 1);
        @(negedge clk);
        check("stall_valid_fell", rsp_valid, 0);
        check("stall_next_ready", req1_ready, 1);
        @(posedge clk); #1 drop_all();
        wait_rsp("rsp_wait_after_stall");
        check("after_stall_id", rsp_id, 1);
        check("after_stall_sum", rsp_sum, 16'h0005);
        @(posedge clk); #1;

        // SETTLE=3 instance: operands held 3 cycles, response exactly 3 edges later
        v3 = 1; a3_in = 16'h00F0; b3_in = 16'h000F; op3 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rdy3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s3_ready", rdy3, 1);
        @(posedge clk); #1 v3 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s3_A_held", A3, 16'h00F0);
            check("s3_B_held", B3, 16'h000F);
            check("s3_ctrl_held", ctrl3, 0);
            check("s3_sum_in_held", SUM3, 16'h00E1);
            check("s3_not_yet_valid", rv3, 0);
        end
        @(negedge clk);
        check("s3_valid", rv3, 1);
        check("s3_sum", rsum3, 16'h00E1);
        check("s3_cout", rcout3, 1);
        check("s3_ovf", rovf3, 0);
        @(posedge clk); #1;

        // Reset during EXEC, then contention after release
        send(0, 16'h1111, 16'h2222, 1'b1);
        req1_valid = 1; req1_A = 16'h0F0F; req1_B = 16'h0101; req1_op = 1'b1;
        rst_n = 0;
        #1;
        check("rst_A", A, 16'h0000);
        check("rst_B", B, 16'h0000);
        check("rst_Add_ctrl", Add_ctrl, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 16'h0000);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #2 rst_n = 1;
        #1;
        check("post_rst_rdy0", req0_ready, 1);
        check("post_rst_rdy1", req1_ready, 0);
        @(posedge clk); #1 drop_all();
        wait_rsp("rsp_wait_post_rst");
        check("post_rst_id", rsp_id, 0);
        check("post_rst_sum", rsp_sum, 16'h3333);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
